fifo_rd_stream: RTL and testbench

//  Read-side drain stage for the async FIFO, in the rclk domain.
//  - Pops words from the FIFO read port (rinc/rdata/rempty).
//  - Presents them on a valid/ready stream through a 2-entry skid buffer.
//  - Frames the stream into fixed-length packets with m_last.
//  - rinc has no combinational path from m_ready.

---
 rtl/fifo_rd_stream.sv | 146 ++++++++++++++
 tb/tb_fifo_rd_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Purpose : read-side drain of the async FIFO; pops show-ahead words into a 2-entry skid buffer and frames them into PKT_LEN-beat packets.
// Latency : a popped word is on m_data the cycle after its rinc pulse; 1 beat/clk sustained while m_ready=1 and the FIFO is not empty.
// Backpres: m_ready=0 fills the skid entry, then rinc stops; rinc depends only on registered occupancy, never on m_ready.
//
// Ports:
//   rclk, rrst_n      read clock, synchronous active-low reset
//   rd_en             drain enable (0 stops popping; buffered words still drain)
//   rempty, rdata     FIFO read port (show-ahead data valid while rempty=0)
//   rinc              pop strobe to the FIFO
//   m_valid/m_data/m_last/m_ready   output stream, m_last on beat PKT_LEN-1
//   beat_total        accepted beats since reset, wraps
//   stall_cnt         cycles with m_valid & ~m_ready, saturating
//                     (present only when FIFO_RD_STATS_EN is defined)
module fifo_rd_stream #(
    parameter int DATA    = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rd_en,
    input  logic             rempty,
    input  logic [DATA-1:0]  rdata,
    output logic             rinc,
    output logic             m_valid,
    output logic [DATA-1:0]  m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] beat_total
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    // Occupancy of the skid buffer: 0, 1 or 2 words held.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA-1:0]   buf0_q, buf0_d;   // word currently presented
    logic [DATA-1:0]   buf1_q, buf1_d;   // skid word behind it
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]  beat_total_q, beat_total_d;

    logic pop;
    logic take;

    // The pop decision uses only registered occupancy plus FIFO/enable
    // inputs, so the FIFO never sees a path from downstream ready.
    // Reset gating keeps the FIFO untouched while rrst_n is low.
    assign pop     = rrst_n & rd_en & ~rempty & (state_q != S2);
    assign rinc    = pop;
    assign m_valid = (state_q != S0);
    assign take    = m_valid & m_ready;
    assign m_data  = buf0_q;
    assign m_last  = m_valid & (beat_idx_q == LAST_IDX);
    assign beat_total = beat_total_q;

    always_comb begin
        state_d      = state_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        beat_idx_d   = beat_idx_q;
        beat_total_d = beat_total_q;

        case (state_q)
            S0: begin
                if (pop) begin
                    state_d = S1;
                    buf0_d  = rdata;
                end
            end
            S1: begin
                if (pop && take) begin
                    buf0_d = rdata;
                end else if (pop) begin
                    // Downstream stalled: park the new word in the skid slot.
                    state_d = S2;
                    buf1_d  = rdata;
                end else if (take) begin
                    state_d = S0;
                end
            end
            S2: begin
                if (take) begin
                    state_d = S1;
                    buf0_d  = buf1_q;
                end
            end
            default: begin
                state_d = S0;
            end
        endcase

        if (take) begin
            beat_idx_d   = (beat_idx_q == LAST_IDX) ? '0 : beat_idx_q + 1'b1;
            beat_total_d = beat_total_q + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q      <= S0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            beat_idx_q   <= '0;
            beat_total_q <= '0;
        end else begin
            state_q      <= state_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            beat_idx_q   <= beat_idx_d;
            beat_total_q <= beat_total_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturates at all-ones so a long stall never reads back as a short one.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !m_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    localparam int DATA    = 8;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rrst_n;
    logic             rd_en;
    logic             rempty;
    logic [DATA-1:0]  rdata;
    logic             rinc;
    logic             m_valid;
    logic [DATA-1:0]  m_data;
    logic             m_last;
    logic             m_ready;
    logic [CNT_W-1:0] beat_total;
`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA(DATA), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
        .rclk       (clk),
        .rrst_n     (rrst_n),
        .rd_en      (rd_en),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .beat_total (beat_total)
`ifdef FIFO_RD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source FIFO contents, words held downstream of the FIFO but not yet
    // accepted, and what the sink has accepted so far.
    logic [DATA-1:0] src[$];
    logic [DATA-1:0] held[$];
    logic [DATA-1:0] sink[$];
    logic            sink_last[$];
    int              take_cyc[$];
    int              pop_cnt = 0;
    int              cyc = 0;
    int              beat = 0;
    logic [31:0]     total = 0;
    logic [31:0]     stall = 0;
    bit              known = 1'b0;
    bit              force_empty = 1'b0;
    bit              toggle_mode = 1'b0;
    bit              rand_ready = 1'b0;

    // Compare process: inputs change just after posedge, so at negedge
    // everything is settled and equals what the next posedge samples.
    always @(negedge clk) begin
        cyc++;
        if (!rrst_n)
            chk("rinc_in_reset", rinc, 0);
        else if (known)
            chk("rinc", rinc, 32'(rd_en && !rempty && held.size() < 2));
        if (known) begin
            chk("m_valid", m_valid, 32'(held.size() != 0));
            if (held.size() != 0) chk("m_data", m_data, held[0]);
            chk("m_last", m_last, 32'(held.size() != 0 && beat == PKT_LEN - 1));
            chk("beat_total", beat_total, total & 32'hFFFF);
`ifdef FIFO_RD_STATS_EN
            chk("stall_cnt", stall_cnt, stall);
`endif
        end
        if (!rrst_n) begin
            held.delete();
            beat  = 0;
            total = 0;
            stall = 0;
            known = 1'b1;
        end else if (known) begin
            if (held.size() != 0 && m_ready) begin
                sink.push_back(held.pop_front());
                sink_last.push_back(beat == PKT_LEN - 1);
                take_cyc.push_back(cyc);
                beat  = (beat + 1) % PKT_LEN;
                total = total + 1;
            end else if (held.size() != 0 && stall != 32'hFFFF) begin
                stall = stall + 1;
            end
            if (rinc === 1'b1 && !rempty && src.size() != 0) begin
                held.push_back(src.pop_front());
                pop_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_mode) force_empty = ~force_empty;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        rempty = (src.size() == 0) || force_empty;
        rdata  = (src.size() != 0) ? src[0] : '0;
    endtask

    task automatic wait_sink(input int n, input int limit, input string name);
        int k = 0;
        while (sink.size() < n && k < limit) begin
            step();
            k++;
        end
        chk(name, 32'(sink.size() >= n), 1);
    endtask

    task automatic clear_sink();
        sink.delete();
        sink_last.delete();
        take_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [DATA-1:0] sent[$];
        logic [DATA-1:0] w;
        int mark;
        int k;

        rrst_n = 1'b0;
        rd_en  = 1'b1;
        m_ready = 1'b1;
        rempty = 1'b1;
        rdata  = '0;

        // Reset held 4 clocks with the FIFO already non-empty.
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_rinc", rinc, 0);
            chk("reset_m_valid", m_valid, 0);
            chk("reset_beat_total", beat_total, 0);
        end
        rrst_n = 1'b1;

        // Back-to-back drain of 8 preloaded words.
        clear_sink();
        wait_sink(8, 40, "burst8_timeout");
        for (int i = 0; i < sink.size(); i++) begin
            chk("burst8_data", sink[i], 32'(8'h10 + i));
            chk("burst8_last", sink_last[i], 32'((i % 4) == 3));
        end
        if (take_cyc.size() == 8) chk("burst8_rate", take_cyc[7] - take_cyc[0], 7);
        chk("burst8_total", beat_total, 8);

        // Stall with three words: two pops fill the buffer, then it holds.
        clear_sink();
        m_ready = 1'b0;
        mark = pop_cnt;
        src.push_back(8'hA0); src.push_back(8'hA1); src.push_back(8'hA2);
        k = 0;
        while (m_valid !== 1'b1 && k < 10) begin step(); k++; end
        chk("stall_valid_timeout", m_valid, 1);
        repeat (5) step();
        chk("stall_pops", pop_cnt - mark, 2);
        chk("stall_data", m_data, 8'hA0);
        m_ready = 1'b1;
        wait_sink(3, 20, "stall_drain_timeout");
        for (int i = 0; i < sink.size(); i++) chk("stall_order", sink[i], 32'(8'hA0 + i));
`ifdef FIFO_RD_STATS_EN
        chk("stall_cnt_5", stall_cnt, 5);
`endif

        // rd_en dropped after two beats of a fresh packet.
        rrst_n = 1'b0; step(); rrst_n = 1'b1;
        clear_sink();
        mark = pop_cnt;
        for (int i = 0; i < 4; i++) src.push_back(8'(8'hB0 + i));
        k = 0;
        while (pop_cnt - mark < 2 && k < 20) begin step(); k++; end
        rd_en = 1'b0;
        mark = pop_cnt;
        repeat (4) step();
        chk("rden_off_pops", pop_cnt - mark, 0);
        chk("rden_off_sink", sink.size(), 2);
        rd_en = 1'b1;
        wait_sink(4, 20, "rden_resume_timeout");
        for (int i = 0; i < sink.size(); i++) begin
            chk("rden_data", sink[i], 32'(8'hB0 + i));
            chk("rden_last", sink_last[i], 32'(i == 3));
        end

        // Toggling empty flag with random backpressure.
        clear_sink();
        for (int i = 0; i < 20; i++) begin
            w = 8'($urandom);
            src.push_back(w);
            sent.push_back(w);
        end
        toggle_mode = 1'b1;
        rand_ready  = 1'b1;
        wait_sink(20, 400, "toggle_timeout");
        toggle_mode = 1'b0;
        rand_ready  = 1'b0;
        force_empty = 1'b0;
        m_ready     = 1'b1;
        for (int i = 0; i < sink.size(); i++) chk("toggle_order", sink[i], sent[i]);

        // Reset while the skid buffer is full, mid-packet.
        clear_sink();
        src.push_back(8'hD0);
        wait_sink(1, 20, "rst_pre_timeout");
        m_ready = 1'b0;
        mark = pop_cnt;
        src.push_back(8'hD1); src.push_back(8'hD2); src.push_back(8'hD3);
        k = 0;
        while (pop_cnt - mark < 2 && k < 20) begin step(); k++; end
        chk("s2_valid", m_valid, 1);
        chk("s2_no_pop", rinc, 0);
        rrst_n = 1'b0; step(); rrst_n = 1'b1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_data", m_data, 0);
        chk("rst_mid_total", beat_total, 0);
        clear_sink();
        m_ready = 1'b1;
        src.push_back(8'hD4); src.push_back(8'hD5); src.push_back(8'hD6);
        wait_sink(4, 30, "rst_post_timeout");
        for (int i = 0; i < sink.size(); i++) begin
            chk("rst_post_data", sink[i], 32'(8'hD3 + i));
            chk("rst_post_last", sink_last[i], 32'(i == 3));
        end
        chk("src_drained", src.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
